uart_tx_arb: RTL

Round-robin arbiter that shares one UART transmitter between N_REQ byte producers, e.g. the receive-echo path, a status reporter and a debug console. It sits between the requesters and the transmitter. It accepts one byte at a time over a valid/ready handshake, issues a single start pulse to the transmitter, and tracks busy/done until the frame completes. It also owns the baud selection and applies a new value only between frames, so a rate change never corrupts a character in flight.

---
 rtl/uart_tx_arb_if.sv | 24 ++
 rtl/uart_tx_arb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb_if.sv
// Requester and transmitter handshake bundle for uart_tx_arb.
// master = arbiter side, slave = requesters plus UART transmitter.
interface uart_tx_arb_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    tx_start;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_busy;
    logic                    tx_done;

    modport master (
        input  req_valid, req_data, tx_busy, tx_done,
        output req_ready, tx_start, tx_data
    );

    modport slave (
        output req_valid, req_data, tx_busy, tx_done,
        input  req_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Optional frame watchdog enabled by defining UART_ARB_WATCHDOG_EN.
module uart_tx_arb #(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 8,
    localparam int IW     = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_arb_if.master       bus,
    input  logic [2:0]          baud_set_in,
    output logic [2:0]          baud_set_out,
    output logic [IW-1:0]       grant_id,
    output logic                active,
    output logic                tx_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [IW-1:0]     ptr_reg, ptr_next;
    logic [DATA_W-1:0] tx_data_reg, tx_data_next;
    logic [IW-1:0]     grant_id_reg, grant_id_next;
    logic [2:0]        baud_reg, baud_next;

    logic [DATA_W-1:0] req_bytes [N_REQ];
    logic [IW-1:0]     winner;
    logic              found;
    logic              grant_ok;
    logic              wd_fire;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_bytes[gi]     = bus.req_data[gi*DATA_W +: DATA_W];
            assign bus.req_ready[gi] = grant_ok && (winner == IW'(gi));
        end
    endgenerate

    // Scan downward over offsets so the lowest offset from ptr wins last.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (bus.req_valid[IW'(idx)]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign grant_ok = (state_reg == IDLE) && found;

`ifdef UART_ARB_WATCHDOG_EN
    logic [7:0] wd_cnt_reg, wd_cnt_next;
    logic       wd_en;

    // In WAIT_DONE a busy transmitter is making progress, so the count pauses.
    always_comb begin
        wd_en   = (state_reg == WAIT_BUSY) ||
                  ((state_reg == WAIT_DONE) && !bus.tx_busy);
        wd_fire = wd_en && !bus.tx_busy && !bus.tx_done && (wd_cnt_reg == 8'd254);
        if (state_next != state_reg) begin
            wd_cnt_next = 8'd0;
        end else if (wd_en) begin
            wd_cnt_next = wd_cnt_reg + 8'd1;
        end else begin
            wd_cnt_next = wd_cnt_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_reg <= 8'd0;
        end else begin
            wd_cnt_reg <= wd_cnt_next;
        end
    end

    assign tx_err = wd_fire;
`else
    assign wd_fire = 1'b0;
    assign tx_err  = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        tx_data_next  = tx_data_reg;
        grant_id_next = grant_id_reg;
        baud_next     = baud_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    tx_data_next  = req_bytes[winner];
                    grant_id_next = winner;
                    ptr_next      = (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    state_next    = ISSUE;
                end else if (baud_set_in <= 3'd4) begin
                    // Rate changes only land between frames; codes 5..7 are ignored.
                    baud_next = baud_set_in;
                end
            end
            ISSUE: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_done) begin
                    state_next = IDLE;
                end else if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (wd_fire) begin
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done || wd_fire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            tx_data_reg  <= '0;
            grant_id_reg <= '0;
            baud_reg     <= 3'd0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            tx_data_reg  <= tx_data_next;
            grant_id_reg <= grant_id_next;
            baud_reg     <= baud_next;
        end
    end

    assign bus.tx_start = (state_reg == ISSUE);
    assign bus.tx_data  = tx_data_reg;
    assign grant_id     = grant_id_reg;
    assign baud_set_out = baud_reg;
    assign active       = (state_reg != IDLE);

endmodule
